// File: rtl/shared_mem_ctrl.sv
// Shared-memory controller: in-order request FIFO feeding a write/read FSM over a register array.
// Optional build macro WR_ACK_EN adds a resp_wr port and a one-cycle acknowledge pulse per write.
module shared_mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [DATA_W-1:0] resp_data,
`ifdef WR_ACK_EN
  output logic              resp_wr,
`endif
  output logic              busy
);

  localparam int WORDS = 1 << ADDR_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  generate
    if (RD_LAT < 1) begin : g_lat_check
      $error("shared_mem_ctrl: RD_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t              state_reg, state_next;
  logic                fifo_op   [DEPTH];
  logic [ADDR_W-1:0]   fifo_addr [DEPTH];
  logic [DATA_W-1:0]   fifo_data [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [LAT_W-1:0]    lat_cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [DATA_W-1:0]   mem [WORDS];
  logic                push, pop;

  assign req_ready = !rst && (count_reg != CNT_W'(DEPTH));
  assign push      = req_valid && req_ready;
  assign pop       = (state_reg == IDLE) && (count_reg != '0);
  assign busy      = (count_reg != '0) || (state_reg != IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (count_reg != '0) state_next = fifo_op[rd_ptr_reg] ? WRITE : READ;
      WRITE:   state_next = IDLE;
      READ:    if (lat_cnt_reg == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FIFO storage is not reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_op[wr_ptr_reg]   <= req_op;
      fifo_addr[wr_ptr_reg] <= req_addr;
      fifo_data[wr_ptr_reg] <= req_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      lat_cnt_reg <= '0;
      addr_reg    <= '0;
      data_reg    <= '0;
      resp_valid  <= 1'b0;
      resp_addr   <= '0;
      resp_data   <= '0;
`ifdef WR_ACK_EN
      resp_wr     <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        addr_reg    <= fifo_addr[rd_ptr_reg];
        data_reg    <= fifo_data[rd_ptr_reg];
        lat_cnt_reg <= LAT_W'(RD_LAT - 1);
      end
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (!push && pop) count_reg <= count_reg - 1'b1;

      if (state_reg == READ) begin
        if (lat_cnt_reg != '0) begin
          lat_cnt_reg <= lat_cnt_reg - 1'b1;
        end else begin
          resp_valid <= 1'b1;
          resp_addr  <= addr_reg;
          resp_data  <= mem[addr_reg];
`ifdef WR_ACK_EN
          resp_wr    <= 1'b0;
`endif
        end
      end
`ifdef WR_ACK_EN
      if (state_reg == WRITE) begin
        resp_valid <= 1'b1;
        resp_wr    <= 1'b1;
        resp_addr  <= addr_reg;
        resp_data  <= data_reg;
      end
`endif
    end
  end

  // One register per word so the whole array clears on reset.
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (rst)
          mem[gi] <= '0;
        else if (state_reg == WRITE && addr_reg == ADDR_W'(gi))
          mem[gi] <= data_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_shared_mem_ctrl.sv
// Directed self-checking bench for shared_mem_ctrl (default parameters, RD_LAT=2, DEPTH=4).
module tb_shared_mem_ctrl;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_op = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       req_ready, resp_valid, busy;
  logic [7:0] resp_addr, resp_data;
`ifdef WR_ACK_EN
  logic       resp_wr;
`endif

  shared_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_addr(resp_addr),
    .resp_data(resp_data),
`ifdef WR_ACK_EN
    .resp_wr(resp_wr),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
    int         c;
  } resp_t;

  resp_t rd_q[$];
  resp_t wa_q[$];
  resp_t mon_r;
  resp_t r;
  int    n_resp = 0;
  logic  prev_v = 1'b0;

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      check("no_back_to_back", {31'd0, prev_v}, 32'd0);
      mon_r.a = resp_addr;
      mon_r.d = resp_data;
      mon_r.c = cyc;
      n_resp++;
`ifdef WR_ACK_EN
      if (resp_wr) begin
        wa_q.push_back(mon_r);
        $display("resp wr-ack addr=%02h data=%02h cyc=%0d", resp_addr, resp_data, cyc);
      end else begin
        rd_q.push_back(mon_r);
        $display("resp read   addr=%02h data=%02h cyc=%0d", resp_addr, resp_data, cyc);
      end
`else
      rd_q.push_back(mon_r);
      $display("resp read   addr=%02h data=%02h cyc=%0d", resp_addr, resp_data, cyc);
`endif
    end
    prev_v = resp_valid;
  end

  int last_acc;

  task automatic send(input logic op, input logic [7:0] a, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("ready_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    $display("req  op=%0d addr=%02h data=%02h acc_cyc=%0d", op, a, d, last_acc);
  endtask

  task automatic idle(input int k);
    if (k > 0) begin
      @(negedge clk);
      req_valid = 1'b0;
      repeat (k - 1) @(negedge clk);
    end
  endtask

  task automatic wait_rd(input int n);
    int t;
    t = 0;
    while (rd_q.size() < n && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("rd_count", rd_q.size(), n);
  endtask

  logic [7:0] ref_mem [8];
  logic [7:0] exp_a[$];
  logic [7:0] exp_d[$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_a, acc_b, n_exp;
    logic       op;
    logic [7:0] a, d;

    // Power-on reset
    @(posedge clk); #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // 1: reset while a read is in flight
    send(1'b1, 8'h3C, 8'h77);
    send(1'b0, 8'h3C, 8'h00);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midread_rst_busy", {31'd0, busy}, 32'd0);
    check("midread_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    #1;
    check("dropped_read_no_resp", n_resp, 0);
    send(1'b0, 8'h3C, 8'h00);
    acc_a = last_acc;
    idle(1);
    wait_rd(1);
    r = rd_q.pop_front();
    check("t1_addr", {24'd0, r.a}, 32'h3C);
    check("t1_data_cleared", {24'd0, r.d}, 32'h00);
    check("t1_latency", r.c - acc_a, LAT + 1);

    // 2: write then read same address
    send(1'b1, 8'h10, 8'hA5);
    send(1'b0, 8'h10, 8'h00);
    acc_a = last_acc;
    idle(1);
    wait_rd(1);
    r = rd_q.pop_front();
    check("t2_addr", {24'd0, r.a}, 32'h10);
    check("t2_data", {24'd0, r.d}, 32'hA5);
    check("t2_latency", r.c - acc_a, 4);
    repeat (4) @(negedge clk);
    #1;
    check("t2_single_resp", rd_q.size(), 0);

    // 3: two reads stall the engine while writes fill the FIFO
    send(1'b0, 8'h10, 8'h00);
    acc_a = last_acc;
    send(1'b0, 8'h3C, 8'h00);
    for (int i = 0; i < 4; i++) send(1'b1, 8'h50 + 8'(i), 8'hC0 + 8'(i));
    acc_b = last_acc;
    check("t3_no_stall_first4", acc_b - acc_a, 5);
    check("t3_full_ready", {31'd0, req_ready}, 32'd0);
    check("t3_full_busy", {31'd0, busy}, 32'd1);
    send(1'b1, 8'h54, 8'hC4);
    check("t3_fifth_held", last_acc - acc_b, 3);
    idle(1);
    wait_rd(2);
    r = rd_q.pop_front();
    check("t3_r1_data", {24'd0, r.d}, 32'hA5);
    r = rd_q.pop_front();
    check("t3_r2_data", {24'd0, r.d}, 32'h00);
    for (int i = 0; i < 5; i++) send(1'b0, 8'h50 + 8'(i), 8'h00);
    idle(1);
    wait_rd(5);
    for (int i = 0; i < 5; i++) begin
      r = rd_q.pop_front();
      check("t3_rb_addr", {24'd0, r.a}, 32'h50 + i);
      check("t3_rb_data", {24'd0, r.d}, 32'hC0 + i);
    end

    // 4: strict ordering on one address
    send(1'b1, 8'h20, 8'h11);
    send(1'b0, 8'h20, 8'h00);
    send(1'b1, 8'h20, 8'h22);
    send(1'b0, 8'h20, 8'h00);
    idle(1);
    wait_rd(2);
    r = rd_q.pop_front();
    check("t4_first", {24'd0, r.d}, 32'h11);
    r = rd_q.pop_front();
    check("t4_second", {24'd0, r.d}, 32'h22);

    // 5: mixed traffic with gaps across pointer wrap, against a reference array
    for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 12; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = 8'h60 + 8'($urandom_range(0, 3));
      d  = 8'($urandom_range(0, 255));
      if (op) begin
        ref_mem[a[2:0]] = d;
      end else begin
        exp_a.push_back(a);
        exp_d.push_back(ref_mem[a[2:0]]);
      end
      send(op, a, d);
      idle($urandom_range(0, 2));
    end
    idle(1);
    n_exp = exp_a.size();
    wait_rd(n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (rd_q.size() > 0) begin
        r = rd_q.pop_front();
        check("t5_addr", {24'd0, r.a}, {24'd0, exp_a[i]});
        check("t5_data", {24'd0, r.d}, {24'd0, exp_d[i]});
      end
    end
    repeat (10) @(negedge clk);
    #1;
    check("t5_no_extra_resp", rd_q.size(), 0);

    // 6: write to top address; acknowledged only in the WR_ACK_EN build
    wa_q.delete();
    acc_a = n_resp;
    send(1'b1, 8'hFF, 8'h5A);
    idle(1);
    repeat (8) @(negedge clk);
    #1;
`ifdef WR_ACK_EN
    check("t6_ack_count", wa_q.size(), 1);
    if (wa_q.size() > 0) begin
      r = wa_q.pop_front();
      check("t6_ack_addr", {24'd0, r.a}, 32'hFF);
      check("t6_ack_data", {24'd0, r.d}, 32'h5A);
    end
`else
    check("t6_silent_write", n_resp - acc_a, 0);
`endif
    send(1'b0, 8'hFF, 8'h00);
    idle(1);
    wait_rd(1);
    r = rd_q.pop_front();
    check("t6_readback", {24'd0, r.d}, 32'h5A);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
